// File: rtl/alu_share_arbiter.sv
// Round-robin sequencer sharing one combinational ALU between two requesters.
// Each operation runs IDLE -> EXEC -> RESP; the ALU result is captured at the end of EXEC.
module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req0_valid,
  input  logic             i_req1_valid,
  output logic             o_req0_ready,
  output logic             o_req1_ready,
  input  logic [WIDTH-1:0] i_req0_op1,
  input  logic [WIDTH-1:0] i_req0_op2,
  input  logic [WIDTH-1:0] i_req1_op1,
  input  logic [WIDTH-1:0] i_req1_op2,
  input  logic [2:0]       i_req0_sel,
  input  logic [2:0]       i_req1_sel,
  output logic             o_rsp0_valid,
  output logic             o_rsp1_valid,
  input  logic             i_rsp0_ready,
  input  logic             i_rsp1_ready,
  output logic [WIDTH-1:0] o_rsp_result,
  output logic             o_rsp_zf,
  output logic [WIDTH-1:0] o_alu_op1,
  output logic [WIDTH-1:0] o_alu_op2,
  output logic [2:0]       o_alu_sel,
  input  logic [WIDTH-1:0] i_alu_result,
  input  logic             i_alu_zf,
  output logic             o_busy,
  output logic [15:0]      o_op_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_owner;
  logic               r_last;
  logic [WIDTH-1:0]   r_alu_op1;
  logic [WIDTH-1:0]   r_alu_op2;
  logic [2:0]         r_alu_sel;
  logic [WIDTH-1:0]   r_rsp_result;
  logic               r_rsp_zf;
  logic [15:0]        r_op_count;
  logic               w_grant0;
  logic               w_grant1;
  logic               w_accept;
  logic               w_rsp_done;

  // On a tie, r_last==1 means requester 1 was served last, so requester 0 wins
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (i_req0_valid && i_req1_valid) begin
      if (r_last) begin
        w_grant0 = 1'b1;
      end else begin
        w_grant1 = 1'b1;
      end
    end else if (i_req0_valid) begin
      w_grant0 = 1'b1;
    end else if (i_req1_valid) begin
      w_grant1 = 1'b1;
    end else begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
    end
  end

  assign o_req0_ready = (r_state == ST_IDLE) & w_grant0 & ~i_rst;
  assign o_req1_ready = (r_state == ST_IDLE) & w_grant1 & ~i_rst;
  assign w_accept     = o_req0_ready | o_req1_ready;
  assign o_rsp0_valid = (r_state == ST_RESP) & ~r_owner;
  assign o_rsp1_valid = (r_state == ST_RESP) & r_owner;
  assign w_rsp_done   = r_owner ? (o_rsp1_valid & i_rsp1_ready) : (o_rsp0_valid & i_rsp0_ready);
  assign o_busy       = (r_state != ST_IDLE);
  assign o_alu_op1    = r_alu_op1;
  assign o_alu_op2    = r_alu_op2;
  assign o_alu_sel    = r_alu_sel;
  assign o_rsp_result = r_rsp_result;
  assign o_rsp_zf     = r_rsp_zf;
  assign o_op_count   = r_op_count;

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_EXEC;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_EXEC: w_state_nxt = ST_RESP;
      ST_RESP: begin
        if (w_rsp_done) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand capture, ownership, and result capture at the end of EXEC
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_owner      <= 1'b0;
      r_last       <= 1'b1;
      r_alu_op1    <= {WIDTH{1'b0}};
      r_alu_op2    <= {WIDTH{1'b0}};
      r_alu_sel    <= 3'b000;
      r_rsp_result <= {WIDTH{1'b0}};
      r_rsp_zf     <= 1'b0;
      r_op_count   <= 16'd0;
    end else begin
      if (w_accept) begin
        r_owner   <= o_req1_ready;
        r_last    <= o_req1_ready;
        r_alu_op1 <= o_req1_ready ? i_req1_op1 : i_req0_op1;
        r_alu_op2 <= o_req1_ready ? i_req1_op2 : i_req0_op2;
        r_alu_sel <= o_req1_ready ? i_req1_sel : i_req0_sel;
      end
      if (r_state == ST_EXEC) begin
        r_rsp_result <= i_alu_result;
        r_rsp_zf     <= i_alu_zf;
        r_op_count   <= r_op_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomised bench for alu_share_arbiter against a transaction-level model,
// with directed scenarios pinning the expected values.
module tb_alu_share_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        v0, v1, rr0, rr1;
  logic [31:0] a0, b0, a1, b1;
  logic [2:0]  s0, s1;
  logic        rdy0, rdy1, rv0, rv1, zf, busy, alu_zf;
  logic [31:0] res, aop1, aop2, alu_res;
  logic [2:0]  asel;
  logic [15:0] cnt;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(32)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(v0), .i_req1_valid(v1),
    .o_req0_ready(rdy0), .o_req1_ready(rdy1),
    .i_req0_op1(a0), .i_req0_op2(b0), .i_req1_op1(a1), .i_req1_op2(b1),
    .i_req0_sel(s0), .i_req1_sel(s1),
    .o_rsp0_valid(rv0), .o_rsp1_valid(rv1),
    .i_rsp0_ready(rr0), .i_rsp1_ready(rr1),
    .o_rsp_result(res), .o_rsp_zf(zf),
    .o_alu_op1(aop1), .o_alu_op2(aop2), .o_alu_sel(asel),
    .i_alu_result(alu_res), .i_alu_zf(alu_zf),
    .o_busy(busy), .o_op_count(cnt)
  );

  function automatic logic [31:0] alu_fn(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
    case (s)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return (a < b) ? 32'd1 : 32'd0;
      3'b100:  return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  assign alu_res = alu_fn(asel, aop1, aop2);
  assign alu_zf  = (alu_res == 32'd0);

  // Transaction-level model: one in-flight op, its age, and the round-robin memory
  bit          m_busy, m_owner, m_last;
  int          m_age;
  logic [31:0] m_a, m_b, m_res;
  logic [2:0]  m_sel;
  logic        m_zf;
  logic [15:0] m_cnt;
  int          n_cmp = 0;
  int          n_err = 0;
  bit          acc0, acc1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_age = 0;
    m_a = 32'd0; m_b = 32'd0; m_sel = 3'b000; m_res = 32'd0; m_zf = 1'b0; m_cnt = 16'd0;
  endtask

  function automatic int winner();
    if (v0 && v1) return m_last ? 0 : 1;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  // Compare every DUT output against the model shortly after the inputs change
  task automatic settle();
    int w;
    #1;
    if (rst) model_reset();
    w = (rst || m_busy) ? -1 : winner();
    chk1("req0_ready", rdy0, w == 0);
    chk1("req1_ready", rdy1, w == 1);
    chk1("rsp0_valid", rv0, m_busy && m_age >= 2 && !m_owner);
    chk1("rsp1_valid", rv1, m_busy && m_age >= 2 && m_owner);
    chk1("busy", busy, m_busy);
    chk("op_count", {16'd0, cnt}, {16'd0, m_cnt});
    chk("rsp_result", res, m_res);
    chk1("rsp_zf", zf, m_zf);
    chk("alu_op1", aop1, m_a);
    chk("alu_op2", aop2, m_b);
    chk("alu_sel", {29'd0, asel}, {29'd0, m_sel});
    acc0 = v0 & rdy0;
    acc1 = v1 & rdy1;
  endtask

  task automatic model_update();
    int w;
    w = winner();
    if (!m_busy) begin
      if (w >= 0) begin
        m_busy = 1'b1; m_owner = (w == 1); m_last = (w == 1); m_age = 1;
        m_a = (w == 1) ? a1 : a0; m_b = (w == 1) ? b1 : b0; m_sel = (w == 1) ? s1 : s0;
      end
    end else if (m_age == 1) begin
      m_res = alu_fn(m_sel, m_a, m_b);
      m_zf = (m_res == 32'd0);
      m_cnt = m_cnt + 16'd1;
      m_age = 2;
    end else if (m_owner ? rr1 : rr0) begin
      m_busy = 1'b0;
      m_age = 0;
    end
  endtask

  task automatic finish_cycle();
    if (!rst) model_update();
    @(negedge clk);
  endtask

  task automatic tick();
    settle();
    finish_cycle();
  endtask

  function automatic logic [31:0] rnd();
    case ($urandom_range(0, 3))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; rr0 = 1'b1; rr1 = 1'b1;
    a0 = 32'd0; b0 = 32'd0; a1 = 32'd0; b1 = 32'd0; s0 = 3'b000; s1 = 3'b000;
    model_reset();
    @(negedge clk);
    settle();
    chk("reset op_count", {16'd0, cnt}, 32'd0);
    chk1("reset busy", busy, 1'b0);
    finish_cycle();
    rst = 1'b0;

    // Reset in the middle of EXEC aborts the op
    v0 = 1'b1; a0 = 32'd5; b0 = 32'd7; s0 = 3'b010;
    settle(); chk1("abort accept", rdy0, 1'b1); finish_cycle();
    v0 = 1'b0; rst = 1'b1;
    settle(); chk1("abort busy", busy, 1'b0); finish_cycle();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk1("abort rsp0_valid", rv0, 1'b0);
      chk("abort op_count", {16'd0, cnt}, 32'd0);
      finish_cycle();
    end

    // Tie: grants alternate starting with requester 0, three cycles apart
    v0 = 1'b1; a0 = 32'hF0F0_F0F0; b0 = 32'h0F0F_0F0F; s0 = 3'b000;
    v1 = 1'b1; a1 = 32'd3; b1 = 32'd3; s1 = 3'b110;
    for (int c = 0; c < 9; c++) begin
      settle();
      chk1("tie req0_ready", rdy0, (c == 0) || (c == 6));
      chk1("tie req1_ready", rdy1, c == 3);
      if (c % 3 == 2) begin
        chk1("tie rsp0_valid", rv0, c != 5);
        chk1("tie rsp1_valid", rv1, c == 5);
        chk("tie result", res, 32'd0);
        chk1("tie zf", zf, 1'b1);
        chk("tie op_count", {16'd0, cnt}, (c + 1) / 3);
      end
      finish_cycle();
    end
    v0 = 1'b0; v1 = 1'b0;

    // Asynchronous reset between edges
    rst = 1'b1;
    settle();
    chk("areset op_count", {16'd0, cnt}, 32'd0);
    chk("areset alu_op1", aop1, 32'd0);
    finish_cycle();
    rst = 1'b0;

    // Single op 5+7 on requester 0
    v0 = 1'b1; a0 = 32'd5; b0 = 32'd7; s0 = 3'b010;
    settle(); chk1("single ready", rdy0, 1'b1); finish_cycle();
    v0 = 1'b0;
    tick();
    settle();
    chk1("single rsp0_valid", rv0, 1'b1);
    chk("single result", res, 32'd12);
    chk1("single zf", zf, 1'b0);
    chk("single op_count", {16'd0, cnt}, 32'd1);
    finish_cycle();

    // Backpressure on requester 1 (SLT 2<9), requester 0 waits with a wrapping add
    v1 = 1'b1; a1 = 32'd2; b1 = 32'd9; s1 = 3'b111; rr1 = 1'b0;
    v0 = 1'b1; a0 = 32'hFFFF_FFFF; b0 = 32'd1; s0 = 3'b010; rr0 = 1'b1;
    settle(); chk1("bp req1_ready", rdy1, 1'b1); finish_cycle();
    v1 = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      if (c == 7) rr1 = 1'b1;
      settle();
      chk1("bp req0_ready", rdy0, 1'b0);
      if (c >= 2) begin
        chk1("bp rsp1_valid", rv1, 1'b1);
        chk("bp result", res, 32'd1);
      end
      finish_cycle();
    end
    settle(); chk1("bp req0_ready after", rdy0, 1'b1); finish_cycle();
    v0 = 1'b0;
    tick();
    settle();
    chk1("wrap rsp0_valid", rv0, 1'b1);
    chk("wrap result", res, 32'd0);
    chk1("wrap zf", zf, 1'b1);
    finish_cycle();

    // Undefined select 011
    v1 = 1'b1; a1 = $urandom; b1 = $urandom; s1 = 3'b011;
    settle(); chk1("undef ready", rdy1, 1'b1); finish_cycle();
    v1 = 1'b0;
    tick();
    settle();
    chk1("undef rsp1_valid", rv1, 1'b1);
    chk("undef result", res, 32'd0);
    chk1("undef zf", zf, 1'b1);
    finish_cycle();

    // Random traffic with random backpressure and occasional resets
    acc0 = 1'b0; acc1 = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (acc0) v0 = 1'b0;
      if (acc1) v1 = 1'b0;
      if (!v0 && $urandom_range(0, 2) == 0) begin
        v0 = 1'b1; a0 = rnd(); b0 = rnd(); s0 = 3'($urandom_range(0, 7));
      end
      if (!v1 && $urandom_range(0, 2) == 0) begin
        v1 = 1'b1; a1 = rnd(); b1 = rnd(); s1 = 3'($urandom_range(0, 7));
      end
      rr0 = ($urandom_range(0, 9) < 7);
      rr1 = ($urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
